// File: rtl/fast_stop_bit_framer.sv
// rtl/fast_stop_bit_framer.sv - byte-serial FAST stop-bit framer feeding round-robin field lanes
// Each payload byte contributes 7 data bits; bit 7 marks the last byte of a field.
module fast_stop_bit_framer #(
   parameter int beat_width = 64,
   parameter int sup_paths  = 4
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 new_message,
   input  logic [beat_width-1:0]                beat_in,
   input  logic [$clog2(beat_width/8+1)-1:0]    beat_bytes,
   input  logic                                 beat_valid,
   output logic                                 beat_ready,
   output logic [beat_width+1:0]                dins [sup_paths],
   output logic [sup_paths-1:0]                 field_valids,
   output logic [sup_paths-1:0]                 field_complete
);
   localparam int nbytes  = beat_width / 8;
   localparam int rw      = $clog2(nbytes + 1);
   localparam int iw      = (nbytes > 1) ? $clog2(nbytes) : 1;
   localparam int cnt_lim = (beat_width + 6) / 7;
   localparam int cw      = $clog2(cnt_lim + 2);
   localparam int lw      = (sup_paths > 1) ? $clog2(sup_paths) : 1;

   logic [beat_width-1:0] buf_q;
   logic [rw-1:0]         rem_q;
   logic [iw-1:0]         idx_q;
   logic [lw-1:0]         lane_ptr;
   logic                  pmap_pending;
   logic [cw-1:0]         cnt_q [sup_paths];

   logic [7:0]            cur_byte;
   logic                  proc;
   logic                  lane_open;
   logic                  abort;
   logic                  start;
   logic [beat_width+1:0] cur;
   logic [beat_width-1:0] nxt_val;
   logic [cw-1:0]         nxt_cnt;
   logic                  nxt_ovf;
   logic                  nxt_pm;
   logic [lw-1:0]         nxt_ptr;

   assign beat_ready = (rem_q == rw'(0)) || (rem_q == rw'(1));
   assign proc       = (rem_q != rw'(0));

   // A field is open only between its first byte and its stop byte; a lane
   // sitting in its complete cycle is free to start the next field.
   always_comb begin
      cur_byte  = buf_q[{idx_q, 3'b000} +: 8];
      lane_open = field_valids[lane_ptr] && !field_complete[lane_ptr];
      abort     = new_message && lane_open;
      start     = !lane_open || new_message;
      cur       = dins[lane_ptr];
      if (start) begin
         nxt_val = {{(beat_width-7){1'b0}}, cur_byte[6:0]};
         nxt_cnt = cw'(1);
         nxt_ovf = 1'b0;
         nxt_pm  = pmap_pending | new_message;
      end else begin
         nxt_val = {cur[beat_width-8:0], cur_byte[6:0]};
         nxt_cnt = (cnt_q[lane_ptr] == cw'(cnt_lim + 1)) ? cnt_q[lane_ptr]
                                                          : cnt_q[lane_ptr] + 1'b1;
         nxt_ovf = cur[beat_width];
         nxt_pm  = cur[beat_width+1];
      end
      if (nxt_cnt > cw'(cnt_lim)) begin
         nxt_ovf = 1'b1;
      end
      nxt_ptr = (lane_ptr == lw'(sup_paths - 1)) ? '0 : lane_ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_q          <= '0;
         rem_q          <= '0;
         idx_q          <= '0;
         lane_ptr       <= '0;
         pmap_pending   <= 1'b0;
         field_valids   <= '0;
         field_complete <= '0;
         for (int l = 0; l < sup_paths; l++) begin
            dins[l]  <= '0;
            cnt_q[l] <= '0;
         end
      end else begin
         if (proc) begin
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 1'b1;
         end
         // A new beat may land on the same edge the last old byte drains.
         if (beat_valid && beat_ready) begin
            buf_q <= beat_in;
            rem_q <= beat_bytes;
            idx_q <= '0;
         end
         if (new_message) begin
            pmap_pending <= 1'b1;
         end
         for (int l = 0; l < sup_paths; l++) begin
            field_complete[l] <= 1'b0;
            if (field_complete[l]) begin
               field_valids[l] <= 1'b0;
            end
         end
         if (abort && !proc) begin
            field_valids[lane_ptr] <= 1'b0;
            dins[lane_ptr]         <= '0;
            cnt_q[lane_ptr]        <= '0;
         end
         if (proc) begin
            field_valids[lane_ptr] <= 1'b1;
            dins[lane_ptr]         <= {nxt_pm, nxt_ovf, nxt_val};
            cnt_q[lane_ptr]        <= nxt_cnt;
            if (start) begin
               pmap_pending <= 1'b0;
            end
            if (cur_byte[7]) begin
               field_complete[lane_ptr] <= 1'b1;
               lane_ptr                 <= nxt_ptr;
            end
         end
      end
   end
endmodule
